// File: rtl/shift_exec_stage_if.sv
// Valid/ready bundle between issue, the shift execute stage and writeback.
// out_carry is present only when SHIFT_EXEC_CARRY_EN is defined.
interface shift_exec_stage_if #(
  parameter int TAGW = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [31:0]     in_data;
  logic [4:0]      in_amt;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic [TAGW-1:0] out_tag;
  logic            out_zero;
  logic            out_neg;
`ifdef SHIFT_EXEC_CARRY_EN
  logic            out_carry;
`endif

  modport master (
    output in_valid, in_op, in_data, in_amt, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero, out_neg
`ifdef SHIFT_EXEC_CARRY_EN
    , input out_carry
`endif
  );

  modport slave (
    input  in_valid, in_op, in_data, in_amt, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero, out_neg
`ifdef SHIFT_EXEC_CARRY_EN
    , output out_carry
`endif
  );
endinterface

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined shift execute stage (SLL/SRL/SRA/ROR) with valid/ready on both sides.
// Define SHIFT_EXEC_CARRY_EN to add out_carry, the last bit shifted out.
module shift_exec_stage #(
  parameter int W    = 32,
  parameter int TAGW = 5
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  shift_exec_stage_if.slave bus
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  logic            s1_valid_q, s1_valid_d;
  shift_op_e       s1_op_q;
  logic [W-1:0]    s1_data_q;
  logic [4:0]      s1_amt_q;
  logic [TAGW-1:0] s1_tag_q;

  logic            s2_valid_q, s2_valid_d;
  logic [W-1:0]    s2_data_q;
  logic [TAGW-1:0] s2_tag_q;
  logic            s2_zero_q;
  logic            s2_neg_q;

  logic            s2_adv, s1_adv, in_fire;
  logic            s1_load, s2_load;
  logic [W-1:0]    result;
  logic [5:0]      rot_left;

  assign s2_adv  = ~s2_valid_q | bus.out_ready;
  assign s1_adv  = s1_valid_q & s2_adv;
  assign in_fire = bus.in_valid & bus.in_ready;
  assign s1_load = in_fire & ~flush;
  assign s2_load = s1_adv & ~flush;

  assign rot_left = 6'(W) - {1'b0, s1_amt_q};

  always_comb begin
    result = s1_data_q;
    case (s1_op_q)
      OP_SLL: result = s1_data_q << s1_amt_q;
      OP_SRL: result = s1_data_q >> s1_amt_q;
      OP_SRA: result = $signed(s1_data_q) >>> s1_amt_q;
      OP_ROR: result = (s1_data_q >> s1_amt_q) | (s1_data_q << rot_left);
      default: result = s1_data_q;
    endcase
  end

  // Flush outranks an incoming op; a new op always outranks S1 draining into S2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid_d = 1'b1;
      end else if (s1_adv) begin
        s1_valid_d = 1'b0;
      end
      if (s1_adv) begin
        s2_valid_d = 1'b1;
      end else if (bus.out_ready) begin
        s2_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_op_q   <= OP_SLL;
      s1_data_q <= '0;
      s1_amt_q  <= '0;
      s1_tag_q  <= '0;
    end else if (s1_load) begin
      s1_op_q   <= shift_op_e'(bus.in_op);
      s1_data_q <= bus.in_data;
      s1_amt_q  <= bus.in_amt;
      s1_tag_q  <= bus.in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_data_q <= '0;
      s2_tag_q  <= '0;
      s2_zero_q <= 1'b0;
      s2_neg_q  <= 1'b0;
    end else if (s2_load) begin
      s2_data_q <= result;
      s2_tag_q  <= s1_tag_q;
      s2_zero_q <= (result == '0);
      s2_neg_q  <= result[W-1];
    end
  end

`ifdef SHIFT_EXEC_CARRY_EN
  logic [4:0] sll_idx, right_idx;
  logic       carry;
  logic       s2_carry_q;

  // Index arithmetic wraps mod 32, so only n = 0 needs the explicit zero.
  assign sll_idx   = 5'd0 - s1_amt_q;
  assign right_idx = s1_amt_q - 5'd1;

  always_comb begin
    carry = 1'b0;
    if (s1_amt_q != 5'd0) begin
      if (s1_op_q == OP_SLL) begin
        carry = s1_data_q[sll_idx];
      end else begin
        carry = s1_data_q[right_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_carry_q <= 1'b0;
    end else if (s2_load) begin
      s2_carry_q <= carry;
    end
  end

  assign bus.out_carry = s2_carry_q;
`endif

  assign bus.in_ready  = ~s1_valid_q | s2_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_tag   = s2_tag_q;
  assign bus.out_zero  = s2_zero_q;
  assign bus.out_neg   = s2_neg_q;

endmodule
